// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   IF stage of the 5-stage MIPS32 pipeline. Owns the PC, drives the word
//   address into the combinational instruction memory and captures the
//   returned word into the IF/ID register. Handles stalls, EX redirects,
//   halt and a fetch counter.
//
//   Optional feature macro: FETCH_ALIGN_CHECK_EN
//     defined   : a redirect to a non-word-aligned target enters the terminal
//                 FAULT state and records the target in fault_pc.
//     undefined : redirect_pc[1:0] is forced to 2'b00; fetch_fault/fault_pc
//                 are tied to 0.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_addr        current PC (registered, no input-to-output path)
//   imem_instr       instruction returned for imem_addr
//   stall            hold PC and IF/ID
//   redirect_valid   taken branch/jump from EX, target on redirect_pc
//   halt_req         stop fetching (terminal until reset)
//   if_id_instr/pc/pc4/valid   IF/ID pipeline register
//   halted           FSM in HALTED or FAULT
//   fetch_fault      sticky misaligned-redirect flag
//   fault_pc         offending redirect target
//   fetch_count      instructions captured with valid=1 (wraps at 2^32)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              halted,
    output logic              fetch_fault,
    output logic [ADDR_W-1:0] fault_pc,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(3);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
`else
    typedef enum logic [0:0] {RUN, HALTED} state_t;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              capture;     // load IF/ID from memory this edge
    logic              squash;      // clear if_id_valid this edge
    logic              fault_set;

    // Next-state and control decode. Priority in RUN:
    // redirect > halt > stall > sequential fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        squash    = 1'b0;
        fault_set = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    squash = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_nxt = FAULT;
                        fault_set = 1'b1;
                    end else begin
                        pc_nxt = redirect_pc;
                    end
`else
                    pc_nxt = redirect_pc & ALIGN_M;
`endif
                end else if (halt_req) begin
                    state_nxt = HALTED;
                    squash    = 1'b1;
                end else if (!stall) begin
                    capture = 1'b1;
                    pc_nxt  = pc + PC_STEP;
                end
            end
            default: begin
                // HALTED / FAULT: terminal, all requests ignored.
                squash = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc <= pc_nxt;
            if (squash) begin
                if_id_valid <= 1'b0;
            end else if (capture) begin
                if_id_instr <= imem_instr;
                if_id_pc    <= pc;
                if_id_pc4   <= pc + PC_STEP;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (fault_set) begin
            fetch_fault <= 1'b1;
            fault_pc    <= redirect_pc;
        end
    end
`else
    assign fetch_fault = 1'b0;
    assign fault_pc    = '0;
`endif

    assign imem_addr = pc;
    assign halted    = (state != RUN);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch (IF) stage of the 5-stage MIPS32 pipeline, sitting directly upstream of `instruction_memory`. It owns the program counter and drives the word address into the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register. It handles hazard stalls, EX-stage redirects (branch/jump), halt and a fetch counter, and presents a valid-qualified instruction to decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000000: PC loaded on reset.
- `ADDR_W`, default 32: PC / address width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_addr`, output, 32: equals the current PC; feeds `instruction_memory.addr`. The memory indexes with `addr[11:2]`.
- `imem_instr`, input, 32: combinational instruction returned for `imem_addr`.
- `stall`, input, 1: hazard-unit stall; holds the PC and IF/ID.
- `redirect_valid`, input, 1: taken branch/jump from EX.
- `redirect_pc`, input, 32: redirect target.
- `halt_req`, input, 1: stop fetching.
- `if_id_instr`, output, 32: registered instruction.
- `if_id_pc`, output, 32: PC of `if_id_instr`.
- `if_id_pc4`, output, 32: `if_id_pc + 4`.
- `if_id_valid`, output, 1: IF/ID holds a live instruction.
- `halted`, output, 1: the FSM is in HALTED or FAULT.
- `fetch_fault`, output, 1: sticky misaligned-redirect flag (see Configuration).
- `fault_pc`, output, 32: offending redirect target.
- `fetch_count`, output, 32: number of instructions captured with valid=1.

## Operation
- FSM states: RUN, HALTED, FAULT. Reset enters RUN.
- Per-edge priority in RUN, highest first:
  1. `redirect_valid`: PC <= `redirect_pc`; `if_id_valid` <= 0 (the wrong-path slot is squashed). This applies even if `stall`=1.
  2. `halt_req`: state <= HALTED; PC holds; `if_id_valid` <= 0.
  3. `stall`: the PC and all IF/ID outputs hold their values, including valid.
  4. Otherwise: `if_id_instr` <= `imem_instr`; `if_id_pc` <= PC; `if_id_pc4` <= PC+4; `if_id_valid` <= 1; PC <= PC+4; `fetch_count` += 1.
- HALTED and FAULT are terminal until `rst_n` is asserted.
  - In these states the PC holds, `if_id_valid` = 0, and `redirect_valid`, `stall` and `halt_req` are ignored.
- Arithmetic:
  - PC+4 is modulo 2^32, so the PC wraps from 32'hFFFFFFFC to 0.
  - Addresses above 4 KB alias in the instruction memory; no range check is done here.
  - `fetch_count` wraps at 2^32.
- `imem_addr` is purely the PC register, with no combinational path from any input. The redirect therefore takes effect on the memory address one cycle after `redirect_valid` is sampled.

## Timing
- Reset values: PC = `RESET_PC`; `imem_addr` = `RESET_PC`; `if_id_instr` = 0; `if_id_pc` = 0; `if_id_pc4` = 0; `if_id_valid` = 0; `halted` = 0; `fetch_fault` = 0; `fault_pc` = 0; `fetch_count` = 0; state = RUN.
- Latency:
  - The instruction at PC X appears on `if_id_instr` with valid=1 one edge after PC = X, provided there is no stall or redirect.
  - Throughput is 1 instruction/cycle.
- Redirect cost: 1 bubble. The edge that samples the redirect produces valid=0, and the next edge captures `mem[redirect_pc]`.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first capture after deassertion is `mem[RESET_PC>>2]` on the first rising edge.
- When `stall` and `halt_req` are asserted together, halt wins.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined: on a redirect with `redirect_pc[1:0]` != 2'b00:
  - state <= FAULT; `fetch_fault` <= 1 (sticky); `fault_pc` <= `redirect_pc`.
  - The PC holds; `if_id_valid` <= 0; `halted` = 1.
- Undefined:
  - `redirect_pc[1:0]` is forced to 2'b00 and the redirect proceeds normally.
  - The FAULT state is not built; `fetch_fault` is tied to 0 and `fault_pc` is tied to 0.

## Test plan
- Reset/sequential fetch:
  - Stimulus: memory model with mem[0]=32'h02114020, mem[1]=32'h02534821, mem[2]=32'h02945022; `RESET_PC`=0; release reset.
  - Required response: after edges 1, 2 and 3, `if_id_instr` = 02114020, 02534821, 02945022 respectively.
  - `if_id_pc` = 0, 4, 8 on the same edges; `fetch_count` = 3.
- Stall:
  - Stimulus: assert `stall` for 2 cycles while `if_id_pc`=4.
  - Required response: outputs frozen (instr 02534821, valid=1) and PC stays 8; after release, the next capture is PC 8.
- Redirect with stall:
  - Stimulus: `redirect_valid`=1, `redirect_pc`=32'h60 (mem[24]=32'h81860004), `stall`=1.
  - Required response: next edge gives valid=0 and `imem_addr`=0x60; the following edge gives `if_id_instr`=81860004 and `if_id_pc`=0x60.
- Halt:
  - Stimulus: `halt_req` pulse, then `redirect_valid` pulses.
  - Required response: `halted`=1, valid=0; PC and `fetch_count` frozen; redirects ignored.
- Misaligned redirect:
  - Stimulus: `redirect_pc`=32'h62.
  - Required response with `FETCH_ALIGN_CHECK_EN`: `fetch_fault`=1, `fault_pc`=0x62, `halted`=1.
  - Required response without it: fetch continues from 0x60.
- Wrap and mid-run reset:
  - Stimulus: redirect to 32'hFFFFFFFC, then let fetch run; separately, pulse `rst_n` low mid-run.
  - Required response: the next PC is 0 after the wrap; the reset pulse immediately returns all outputs to their reset values.
